// File: rtl/spi_chain_ctrl.sv
// spi_chain_ctrl: SPI-style master for the on-chip scan/load chain.
// Shifts a parallel write word MSB-first into the chain, captures the chain's
// previous contents from the serial return line, then pulses load to commit.
//
// Ports:
//   i_clk       system clock (also the chain's sampling clock)
//   i_resetn    asynchronous active-low reset, released synchronously
//   i_start     transaction request, only honoured in IDLE
//   i_wdata     write word, latched when i_start is accepted
//   o_busy      high for the whole transaction (SETUP..LOAD)
//   o_done      one-cycle completion pulse
//   o_rdata     previous chain contents, updated with o_done
//   o_spi_clk   chain SCLK
//   o_spi_dat   chain MOSI
//   o_spi_load  chain nCS/load, high = load/idle
//   i_spi_dat   chain MISO (scan MSB)
module spi_chain_ctrl #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4     // i_clk cycles per SPI phase, 2..255
) (
    input  logic              i_clk,
    input  logic              i_resetn,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_spi_clk,
    output logic              o_spi_dat,
    output logic              o_spi_load,
    input  logic              i_spi_dat
);

    localparam int PH_W  = 8;
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_HIGH,
        S_LOAD,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PH_W-1:0]    ph_q;
    logic [CNT_W-1:0]   bit_q;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  cap_q;
    logic               phase_end;
    logic               last_bit;

    // Reset asserts immediately, releases two i_clk edges later.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) rst_sync_q <= 2'b00;
        else           rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign phase_end = (ph_q == PH_W'(CLK_DIV - 1));
    assign last_bit  = (bit_q == CNT_W'(DATA_W - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start)  state_d = S_SETUP;
            S_SETUP: if (phase_end) state_d = S_LOW;
            S_LOW:   if (phase_end) state_d = S_HIGH;
            // Counter increments on HIGH exit; DATA_W reached means last bit done.
            S_HIGH:  if (phase_end) state_d = last_bit ? S_LOAD : S_LOW;
            S_LOAD:  if (phase_end) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        if (state_q == S_IDLE && i_start)
            shift_d = i_wdata;
        else if (state_q == S_HIGH && phase_end)
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
    end

    // All chain-facing outputs are registered from the next state so the
    // chain never sees a decode glitch.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ph_q       <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            cap_q      <= '0;
            o_rdata    <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_spi_clk  <= 1'b0;
            o_spi_dat  <= 1'b0;
            o_spi_load <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;

            if (state_d != state_q || state_q == S_IDLE) ph_q <= '0;
            else                                         ph_q <= ph_q + PH_W'(1);

            if (state_q == S_IDLE)                   bit_q <= '0;
            else if (state_q == S_HIGH && phase_end) bit_q <= bit_q + CNT_W'(1);

            // Sample MISO on the last LOW cycle, i.e. just before the rising edge.
            if (state_q == S_LOW && phase_end)
                cap_q <= {cap_q[DATA_W-2:0], i_spi_dat};

            if (state_d == S_DONE) o_rdata <= cap_q;

            o_busy     <= (state_d inside {S_SETUP, S_LOW, S_HIGH, S_LOAD});
            o_done     <= (state_d == S_DONE);
            o_spi_clk  <= (state_d == S_HIGH);
            o_spi_load <= !(state_d inside {S_SETUP, S_LOW, S_HIGH});

            // Data moves only on SETUP/LOW entry; held through HIGH and LOAD
            // so the last bit keeps its hold time while load rises.
            if (state_d == S_SETUP || state_d == S_LOW)
                o_spi_dat <= shift_d[DATA_W-1];
            else if (state_d == S_DONE || state_d == S_IDLE)
                o_spi_dat <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_chain_ctrl.sv
// Bench for spi_chain_ctrl: a behavioural 16-bit scan/load chain is wired to
// the DUT; a line monitor measures busy length, SCLK edges, serialized bits,
// setup/hold of MOSI and load timing, and a scoreboard tracks what the chain
// scan register should hold so the expected readback is known.
module tb_spi_chain_ctrl;

    localparam int DW  = 16;
    localparam int DIV = 4;
    localparam int BUSY_LEN = (2 * DW + 2) * DIV;

    logic          i_clk = 1'b0;
    logic          i_resetn = 1'b0;
    logic          i_start = 1'b0;
    logic [DW-1:0] i_wdata = '0;
    logic          o_busy, o_done, o_spi_clk, o_spi_dat, o_spi_load;
    logic [DW-1:0] o_rdata;
    logic          i_spi_dat;

    spi_chain_ctrl #(.DATA_W(DW), .CLK_DIV(DIV)) dut (
        .i_clk      (i_clk),
        .i_resetn   (i_resetn),
        .i_start    (i_start),
        .i_wdata    (i_wdata),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_rdata    (o_rdata),
        .o_spi_clk  (o_spi_clk),
        .o_spi_dat  (o_spi_dat),
        .o_spi_load (o_spi_load),
        .i_spi_dat  (i_spi_dat)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- chain model ----------------
    // Shifts MOSI on SCLK rise, commits scan->data on load rise.
    // ch_det is the chain's detect flag, modelled as the committed MSB.
    logic [DW-1:0] ch_scan, ch_data;
    logic          ch_sclk_q, ch_load_q;
    logic          pre_req = 1'b0;
    logic [DW-1:0] pre_val = '0;
    logic          ch_det;

    always @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            ch_scan   <= '0;
            ch_data   <= '0;
            ch_sclk_q <= 1'b0;
            ch_load_q <= 1'b1;
        end else begin
            ch_sclk_q <= o_spi_clk;
            ch_load_q <= o_spi_load;
            if (pre_req)                      ch_scan <= pre_val;
            else if (o_spi_clk && !ch_sclk_q) ch_scan <= {ch_scan[DW-2:0], o_spi_dat};
            if (o_spi_load && !ch_load_q)     ch_data <= ch_scan;
        end
    end
    assign i_spi_dat = ch_scan[DW-1];
    assign ch_det    = ch_data[DW-1];

    // ---------------- line monitor ----------------
    int            busy_cnt = 0, rise_cnt = 0, fall_cnt = 0, load_fall_at = -1;
    int            min_setup = 999, hold_viol = 0, load_viol = 0, dat_age = 0;
    int            done_total = 0, busy_rises = 0;
    logic [DW-1:0] bits_q = '0;
    logic          p_clk = 1'b0, p_dat = 1'b0, p_load = 1'b1, p_busy = 1'b0;

    always @(negedge i_clk) begin
        if (o_busy && !p_busy) begin
            busy_cnt = 0; rise_cnt = 0; fall_cnt = 0; bits_q = '0;
            min_setup = 999; hold_viol = 0; load_viol = 0; load_fall_at = -1;
            busy_rises++;
        end
        if (o_busy) busy_cnt++;
        if (o_spi_dat != p_dat) dat_age = 1;
        else                    dat_age++;
        if (o_spi_clk && !p_clk) begin
            rise_cnt++;
            bits_q = {bits_q[DW-2:0], o_spi_dat};
            // samples before this rise during which MOSI was already stable
            if (dat_age - 1 < min_setup) min_setup = dat_age - 1;
        end
        if (!o_spi_clk && p_clk) fall_cnt++;
        if (o_spi_clk && p_clk && o_spi_dat != p_dat) hold_viol++;
        if (o_spi_clk && o_spi_load != p_load) load_viol++;
        if (o_spi_load && !p_load) load_fall_at = o_spi_clk ? -2 : fall_cnt;
        if (o_done) done_total++;
        p_clk = o_spi_clk; p_dat = o_spi_dat; p_load = o_spi_load; p_busy = o_busy;
    end

    // ---------------- checking ----------------
    int n_chk = 0, n_fail = 0;
    logic [DW-1:0] exp_scan = '0;   // what the chain scan register should hold

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge i_clk);
            #1;
        end
    endtask

    task automatic preload(input logic [DW-1:0] v);
        pre_val = v;
        pre_req = 1'b1;
        cyc(1);
        pre_req = 1'b0;
        exp_scan = v;
    endtask

    task automatic start_txn(input logic [DW-1:0] w);
        i_wdata = w;
        i_start = 1'b1;
        cyc(1);
        i_start = 1'b0;
        i_wdata = DW'($urandom);   // must not disturb the accepted word
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cyc(1);
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic finish_txn(input logic [DW-1:0] w, input bit poke);
        bit ok;
        wait_done(ok);
        chk("done_seen", 32'(ok), 32'd1);
        if (ok) begin
            if (poke) i_start = 1'b1;
            chk("rdata", 32'(o_rdata), 32'(exp_scan));
            chk("busy_at_done", 32'(o_busy), 32'd0);
            chk("busy_len", 32'(busy_cnt), 32'(BUSY_LEN));
            chk("rises", 32'(rise_cnt), 32'(DW));
            chk("bits", 32'(bits_q), 32'(w));
            chk("setup_ok", 32'(min_setup >= DIV), 32'd1);
            chk("hold_viol", 32'(hold_viol), 32'd0);
            chk("load_viol", 32'(load_viol), 32'd0);
            chk("load_after_fall", 32'(load_fall_at), 32'(DW));
            chk("chain_data", 32'(ch_data), 32'(w));
            chk("chain_det", 32'(ch_det), 32'(w[DW-1]));
            exp_scan = w;
            cyc(1);
            if (poke) i_start = 1'b0;
            chk("done_pulse", 32'(o_done), 32'd0);
            chk("idle_busy", 32'(o_busy), 32'd0);
        end
    endtask

    task automatic run_txn(input logic [DW-1:0] w);
        start_txn(w);
        finish_txn(w, 1'b0);
    endtask

    initial begin
        int d0, b0;
        bit found;
        logic [DW-1:0] w;

        // reset and idle
        cyc(3);
        chk("rst_load", 32'(o_spi_load), 32'd1);
        i_resetn = 1'b1;
        cyc(10);
        chk("idle_load", 32'(o_spi_load), 32'd1);
        chk("idle_clk",  32'(o_spi_clk),  32'd0);
        chk("idle_dat",  32'(o_spi_dat),  32'd0);
        chk("idle_busy", 32'(o_busy),     32'd0);
        chk("idle_done", 32'(o_done),     32'd0);
        chk("idle_rdata", 32'(o_rdata),   32'd0);

        // directed transactions
        run_txn(16'hCAFE);
        run_txn(16'h1234);
        run_txn(16'hA5A5);

        // starts outside IDLE are ignored
        d0 = done_total; b0 = busy_rises;
        w = 16'h5A3C;
        start_txn(w);
        cyc(3);  i_start = 1'b1; cyc(1); i_start = 1'b0;
        cyc(44); i_start = 1'b1; cyc(1); i_start = 1'b0;
        finish_txn(w, 1'b1);
        cyc(300);
        chk("ignored_dones", 32'(done_total - d0), 32'd1);
        chk("ignored_busy",  32'(busy_rises - b0), 32'd1);

        // i_start held: done, one idle cycle, busy again
        w = 16'h0F0F;
        i_wdata = w;
        i_start = 1'b1;
        cyc(1);
        finish_txn(w, 1'b0);
        cyc(1);
        chk("b2b_busy", 32'(o_busy), 32'd1);
        i_start = 1'b0;
        finish_txn(w, 1'b0);

        // randomized transactions, sometimes with a random pre-existing scan
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1) preload(DW'($urandom));
            run_txn(DW'($urandom));
        end

        // reset during HIGH phase of bit 7
        start_txn(DW'($urandom));
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cyc(1);
            if (rise_cnt == 8 && o_spi_clk) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_bit7", 32'(found), 32'd1);
        cyc(1);
        d0 = done_total;
        i_resetn = 1'b0;
        #1;
        chk("mid_rst_load", 32'(o_spi_load), 32'd1);
        chk("mid_rst_clk",  32'(o_spi_clk),  32'd0);
        chk("mid_rst_dat",  32'(o_spi_dat),  32'd0);
        chk("mid_rst_busy", 32'(o_busy),     32'd0);
        chk("mid_rst_rdata", 32'(o_rdata),   32'd0);
        cyc(3);
        i_resetn = 1'b1;
        exp_scan = '0;
        cyc(5);
        chk("mid_rst_nodone", 32'(done_total - d0), 32'd0);
        run_txn(DW'($urandom));
        run_txn(16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
